mem_ctrl: RTL and testbench
===========================

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter ADDR_W, 16, address width for all address ports.
REQ-002 Parameter INSTR_BASE, 16'h0000, first legal instruction address.
REQ-003 Parameter INSTR_LIMIT, 16'h4000, first illegal instruction address above the segment.
REQ-004 Parameter DATA_BASE, 16'h4000, first legal data address.
REQ-005 Parameter DATA_LIMIT, 16'h8000, first illegal data address above the segment.
REQ-006 Parameter TIMEOUT, 15, maximum number of cycles to wait for mem_ack.
REQ-007 The block SHALL use one clock and a synchronous, active-high reset.
REQ-008 clk  in  1  clock; all state changes on the rising edge.
REQ-009 rst  in  1  synchronous reset, active high.
REQ-010 instr_req  in  1  instruction fetch request; held high until completion or segv.
REQ-011 instr_addr  in  ADDR_W  fetch address.
REQ-012 data_req  in  1  load/store request; held high until completion or segv.
REQ-013 data_we  in  1  1 = store, 0 = load.
REQ-014 data_addr  in  ADDR_W  load/store address.
REQ-015 data_wdata  in  32  store data.
REQ-016 wait_instr  out  1  0 for exactly one cycle when the fetch completes; 1 otherwise.
REQ-017 wait_data  out  1  0 for exactly one cycle when the load/store completes; 1 otherwise.
REQ-018 instr_segv  out  1  one-cycle pulse on an illegal fetch or a fetch timeout.
REQ-019 data_segv  out  1  one-cycle pulse on an illegal load/store or a load/store timeout.
REQ-020 instr_rdata  out  32  fetched word; valid while wait_instr=0 and held until the next fetch completes.
REQ-021 data_rdata  out  32  loaded word; valid while wait_data=0 and held until the next load completes.
REQ-022 mem_req, mem_we, mem_addr[ADDR_W-1:0], mem_wdata[31:0]  out  backing-memory request, all registered.
REQ-023 mem_rdata[31:0], mem_ack  in  backing-memory read data and one-cycle completion.

Function
REQ-024 States SHALL be IDLE, I_ACC, D_ACC, I_DONE, D_DONE, I_SEGV and D_SEGV.
REQ-025 Legality: an address is legal iff BASE <= addr < LIMIT for its segment and addr[1:0] == 2'b00.
REQ-026 In IDLE with data_req=1, go to D_ACC if data_addr is legal, otherwise to D_SEGV.
REQ-027 In IDLE with data_req=0 and instr_req=1, go to I_ACC if instr_addr is legal, otherwise to I_SEGV.
REQ-028 When both requests are high in IDLE, data SHALL win and instr_req stays pending.
REQ-029 Entering I_ACC or D_ACC SHALL register mem_req=1, mem_addr, mem_we (0 for fetch, data_we for data) and mem_wdata.
REQ-030 These outputs SHALL stay stable until mem_ack is sampled.
REQ-031 In I_ACC/D_ACC with mem_ack=1, clear mem_req, capture mem_rdata into the matching rdata register, and go to I_DONE/D_DONE.
REQ-032 A store (mem_we=1) SHALL leave data_rdata unchanged.
REQ-033 I_DONE/D_DONE drive wait_instr/wait_data=0 for one cycle, then return to IDLE.
REQ-034 I_SEGV/D_SEGV drive instr_segv/data_segv=1 for one cycle, issue no memory request, keep wait high, then return to IDLE.
REQ-035 A 4-bit timeout counter SHALL clear on ACC entry and increment each ACC cycle without mem_ack.
REQ-036 When the counter reaches TIMEOUT, clear mem_req and go to the matching SEGV state.
REQ-037 mem_ack sampled in any state other than ACC SHALL be ignored.
REQ-038 If a request drops during ACC, the memory access SHALL still finish and the DONE cycle SHALL still occur; the requester ignores it.
REQ-039 Minimum latency: request sampled at edge N gives mem_req high from N+1; mem_ack at edge N+1 gives wait low in cycle N+2 to N+3.
REQ-040 A request still high in IDLE after DONE or SEGV SHALL start a new transaction; no request is remembered across IDLE.

Reset
REQ-041 rst=1 at an edge SHALL force IDLE, wait_instr=1, wait_data=1, instr_segv=0, data_segv=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, instr_rdata=0, data_rdata=0, timeout counter=0.
REQ-042 Reset during ACC SHALL drop mem_req on the next cycle and produce no DONE or SEGV pulse.

Verification
REQ-043 Fetch at 16'h0010, mem_ack one cycle after mem_req with mem_rdata=32'hDEADBEEF -> wait_instr=0 for one cycle, instr_rdata=32'hDEADBEEF, wait_data stays 1.
REQ-044 Load at 16'h3FFC (out of segment) -> data_segv one-cycle pulse, mem_req never rises, wait_data stays 1.
REQ-045 Load at 16'h4002 (misaligned) -> data_segv pulse, no memory access.
REQ-046 instr_req and data_req high together, store to 16'h4000 of 32'h12345678 -> store first (mem_we=1, mem_wdata=32'h12345678), then the fetch.
REQ-047 Fetch with mem_ack never asserted -> mem_req high for 15 cycles, then instr_segv pulse, then IDLE.
REQ-048 rst asserted two cycles into a data access -> mem_req=0 next cycle, wait_data=1, no segv pulse, later mem_ack ignored.

Source files
------------

// File: rtl/mem_ctrl.sv
// Arbitrates instruction fetches and loads/stores onto one registered backing-memory port, with segment/alignment checks and an ack timeout.
// Latency: mem_req rises the cycle after a request is sampled, and wait_* drops for one cycle after mem_ack. Requesters are stalled by holding wait_* high.
module mem_ctrl #(
   parameter int                ADDR_W      = 16,
   parameter logic [ADDR_W-1:0] INSTR_BASE  = 'h0000,
   parameter logic [ADDR_W-1:0] INSTR_LIMIT = 'h4000,
   parameter logic [ADDR_W-1:0] DATA_BASE   = 'h4000,
   parameter logic [ADDR_W-1:0] DATA_LIMIT  = 'h8000,
   parameter int                TIMEOUT     = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              instr_req,
   input  logic [ADDR_W-1:0] instr_addr,
   input  logic              data_req,
   input  logic              data_we,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [31:0]       data_wdata,
   output logic              wait_instr,
   output logic              wait_data,
   output logic              instr_segv,
   output logic              data_segv,
   output logic [31:0]       instr_rdata,
   output logic [31:0]       data_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ack
);

   typedef enum logic [2:0] {
      IDLE, I_ACC, D_ACC, I_DONE, D_DONE, I_SEGV, D_SEGV
   } state_t;

   localparam logic [3:0] TO_LAST = 4'(TIMEOUT - 1);

   state_t              state_q, state_d;
   logic                mem_req_q, mem_req_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [31:0]         mem_wdata_q, mem_wdata_d;
   logic [31:0]         instr_rdata_q, instr_rdata_d;
   logic [31:0]         data_rdata_q, data_rdata_d;
   logic [3:0]          cnt_q, cnt_d;

   function automatic logic is_legal(input logic [ADDR_W-1:0] a,
                                     input logic [ADDR_W-1:0] base,
                                     input logic [ADDR_W-1:0] limit);
      return (a >= base) && (a < limit) && (a[1:0] == 2'b00);
   endfunction

   always_comb begin
      state_d       = state_q;
      mem_req_d     = mem_req_q;
      mem_we_d      = mem_we_q;
      mem_addr_d    = mem_addr_q;
      mem_wdata_d   = mem_wdata_q;
      instr_rdata_d = instr_rdata_q;
      data_rdata_d  = data_rdata_q;
      cnt_d         = cnt_q;
      case (state_q)
         IDLE: begin
            // Data port has priority; a losing fetch simply stays pending.
            if (data_req) begin
               if (is_legal(data_addr, DATA_BASE, DATA_LIMIT)) begin
                  state_d     = D_ACC;
                  mem_req_d   = 1'b1;
                  mem_we_d    = data_we;
                  mem_addr_d  = data_addr;
                  mem_wdata_d = data_wdata;
                  cnt_d       = 4'd0;
               end else begin
                  state_d = D_SEGV;
               end
            end else if (instr_req) begin
               if (is_legal(instr_addr, INSTR_BASE, INSTR_LIMIT)) begin
                  state_d     = I_ACC;
                  mem_req_d   = 1'b1;
                  mem_we_d    = 1'b0;
                  mem_addr_d  = instr_addr;
                  mem_wdata_d = 32'd0;
                  cnt_d       = 4'd0;
               end else begin
                  state_d = I_SEGV;
               end
            end
         end
         I_ACC, D_ACC: begin
            if (mem_ack) begin
               mem_req_d = 1'b0;
               if (state_q == I_ACC) begin
                  instr_rdata_d = mem_rdata;
                  state_d       = I_DONE;
               end else begin
                  if (!mem_we_q) data_rdata_d = mem_rdata;
                  state_d = D_DONE;
               end
            end else begin
               cnt_d = cnt_q + 4'd1;
               // Counter reaches TIMEOUT on this edge: abandon the access.
               if (cnt_q == TO_LAST) begin
                  mem_req_d = 1'b0;
                  state_d   = (state_q == I_ACC) ? I_SEGV : D_SEGV;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         mem_req_q     <= 1'b0;
         mem_we_q      <= 1'b0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= 32'd0;
         instr_rdata_q <= 32'd0;
         data_rdata_q  <= 32'd0;
         cnt_q         <= 4'd0;
      end else begin
         state_q       <= state_d;
         mem_req_q     <= mem_req_d;
         mem_we_q      <= mem_we_d;
         mem_addr_q    <= mem_addr_d;
         mem_wdata_q   <= mem_wdata_d;
         instr_rdata_q <= instr_rdata_d;
         data_rdata_q  <= data_rdata_d;
         cnt_q         <= cnt_d;
      end
   end

   assign wait_instr  = (state_q != I_DONE);
   assign wait_data   = (state_q != D_DONE);
   assign instr_segv  = (state_q == I_SEGV);
   assign data_segv   = (state_q == D_SEGV);
   assign instr_rdata = instr_rdata_q;
   assign data_rdata  = data_rdata_q;
   assign mem_req     = mem_req_q;
   assign mem_we      = mem_we_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: reset, fetch, load, segment/alignment faults, priority, timeout, back-to-back, reset mid-access.
module tb_mem_ctrl;
   logic        clk = 1'b0;
   logic        rst;
   logic        instr_req, data_req, data_we, mem_ack;
   logic [15:0] instr_addr, data_addr;
   logic [31:0] data_wdata, mem_rdata;
   logic        wait_instr, wait_data, instr_segv, data_segv;
   logic [31:0] instr_rdata, data_rdata, mem_wdata;
   logic        mem_req, mem_we;
   logic [15:0] mem_addr;
   int          n_checks = 0;
   int          n_fail = 0;

   mem_ctrl dut (
      .clk(clk), .rst(rst),
      .instr_req(instr_req), .instr_addr(instr_addr),
      .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
      .wait_instr(wait_instr), .wait_data(wait_data),
      .instr_segv(instr_segv), .data_segv(data_segv),
      .instr_rdata(instr_rdata), .data_rdata(data_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; instr_req = 0; data_req = 0; data_we = 0; mem_ack = 0;
      instr_addr = 0; data_addr = 0; data_wdata = 0; mem_rdata = 0;
      step(); step();
      rst = 1'b0;
      n_checks++; if (wait_instr !== 1'b1) begin n_fail++; $display("FAIL reset_wait_instr got %b exp 1", wait_instr); end
      n_checks++; if (wait_data !== 1'b1) begin n_fail++; $display("FAIL reset_wait_data got %b exp 1", wait_data); end
      n_checks++; if ({instr_segv, data_segv} !== 2'b00) begin n_fail++; $display("FAIL reset_segv got %b exp 00", {instr_segv, data_segv}); end
      n_checks++; if ({mem_req, mem_we} !== 2'b00) begin n_fail++; $display("FAIL reset_mem_req_we got %b exp 00", {mem_req, mem_we}); end
      n_checks++; if (mem_addr !== 16'h0 || mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_mem_bus got %h/%h exp 0/0", mem_addr, mem_wdata); end
      n_checks++; if (instr_rdata !== 32'h0 || data_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h/%h exp 0/0", instr_rdata, data_rdata); end
   endtask

   task automatic test_fetch();
      instr_req = 1; instr_addr = 16'h0010;
      step();
      n_checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0010 || mem_we !== 1'b0) begin n_fail++; $display("FAIL fetch_issue got req=%b addr=%h we=%b exp 1/0010/0", mem_req, mem_addr, mem_we); end
      mem_ack = 1; mem_rdata = 32'hDEADBEEF;
      step();
      mem_ack = 0; instr_req = 0;
      n_checks++; if (wait_instr !== 1'b0 || wait_data !== 1'b1) begin n_fail++; $display("FAIL fetch_done_wait got wi=%b wd=%b exp 0/1", wait_instr, wait_data); end
      n_checks++; if (instr_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL fetch_rdata got %h exp deadbeef", instr_rdata); end
      n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL fetch_req_clear got %b exp 0", mem_req); end
      step();
      n_checks++; if (wait_instr !== 1'b1 || instr_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL fetch_hold got wi=%b rdata=%h exp 1/deadbeef", wait_instr, instr_rdata); end
   endtask

   task automatic test_load_upper_edge();
      data_req = 1; data_we = 0; data_addr = 16'h7FFC;
      step();
      n_checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h7FFC || mem_we !== 1'b0) begin n_fail++; $display("FAIL load_issue got req=%b addr=%h we=%b exp 1/7ffc/0", mem_req, mem_addr, mem_we); end
      mem_ack = 1; mem_rdata = 32'hA5A55A5A;
      step();
      mem_ack = 0; data_req = 0;
      n_checks++; if (wait_data !== 1'b0 || data_rdata !== 32'hA5A55A5A) begin n_fail++; $display("FAIL load_done got wd=%b rdata=%h exp 0/a5a55a5a", wait_data, data_rdata); end
      step();
   endtask

   task automatic test_segv();
      logic [15:0] addrs [3];
      addrs[0] = 16'h3FFC; addrs[1] = 16'h4002; addrs[2] = 16'h8000;
      for (int i = 0; i < 3; i++) begin
         data_req = 1; data_we = 0; data_addr = addrs[i];
         step();
         data_req = 0;
         n_checks++; if (data_segv !== 1'b1 || mem_req !== 1'b0 || wait_data !== 1'b1) begin n_fail++; $display("FAIL dsegv_%h got segv=%b req=%b wd=%b exp 1/0/1", addrs[i], data_segv, mem_req, wait_data); end
         step();
         n_checks++; if (data_segv !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL dsegv_end_%h got segv=%b req=%b exp 0/0", addrs[i], data_segv, mem_req); end
      end
      instr_req = 1; instr_addr = 16'h4000;
      step();
      instr_req = 0;
      n_checks++; if (instr_segv !== 1'b1 || data_segv !== 1'b0 || mem_req !== 1'b0 || wait_instr !== 1'b1) begin n_fail++; $display("FAIL isegv got is=%b ds=%b req=%b wi=%b exp 1/0/0/1", instr_segv, data_segv, mem_req, wait_instr); end
      step();
   endtask

   task automatic test_priority();
      instr_req = 1; instr_addr = 16'h0020;
      data_req = 1; data_we = 1; data_addr = 16'h4000; data_wdata = 32'h12345678;
      step();
      n_checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'h4000 || mem_wdata !== 32'h12345678) begin n_fail++; $display("FAIL prio_store got req=%b we=%b addr=%h wd=%h exp 1/1/4000/12345678", mem_req, mem_we, mem_addr, mem_wdata); end
      step();
      n_checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h4000 || mem_wdata !== 32'h12345678) begin n_fail++; $display("FAIL prio_stable got req=%b addr=%h wd=%h exp 1/4000/12345678", mem_req, mem_addr, mem_wdata); end
      mem_ack = 1; mem_rdata = 32'hCAFEF00D;
      step();
      mem_ack = 0; data_req = 0;
      n_checks++; if (wait_data !== 1'b0 || wait_instr !== 1'b1 || data_rdata !== 32'hA5A55A5A) begin n_fail++; $display("FAIL prio_store_done got wd=%b wi=%b rdata=%h exp 0/1/a5a55a5a", wait_data, wait_instr, data_rdata); end
      step();
      step();
      n_checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h0020) begin n_fail++; $display("FAIL prio_fetch got req=%b we=%b addr=%h exp 1/0/0020", mem_req, mem_we, mem_addr); end
      mem_ack = 1; mem_rdata = 32'h11112222;
      step();
      mem_ack = 0; instr_req = 0;
      n_checks++; if (wait_instr !== 1'b0 || instr_rdata !== 32'h11112222) begin n_fail++; $display("FAIL prio_fetch_done got wi=%b rdata=%h exp 0/11112222", wait_instr, instr_rdata); end
      step();
   endtask

   task automatic test_timeout();
      int cyc = 0;
      instr_req = 1; instr_addr = 16'h0100;
      step();
      while (mem_req === 1'b1 && cyc < 40) begin
         cyc++;
         step();
      end
      n_checks++; if (cyc != 15) begin n_fail++; $display("FAIL timeout_len got %0d cycles exp 15", cyc); end
      n_checks++; if (instr_segv !== 1'b1 || wait_instr !== 1'b1) begin n_fail++; $display("FAIL timeout_segv got segv=%b wi=%b exp 1/1", instr_segv, wait_instr); end
      instr_req = 0;
      step();
      n_checks++; if (instr_segv !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL timeout_idle got segv=%b req=%b exp 0/0", instr_segv, mem_req); end
   endtask

   task automatic test_back_to_back();
      instr_req = 1; instr_addr = 16'h0030;
      step();
      mem_ack = 1; mem_rdata = 32'h0000AAAA;
      step();
      mem_ack = 0;
      n_checks++; if (wait_instr !== 1'b0) begin n_fail++; $display("FAIL b2b_done1 got %b exp 0", wait_instr); end
      step();
      n_checks++; if (mem_req !== 1'b0 || wait_instr !== 1'b1) begin n_fail++; $display("FAIL b2b_idle got req=%b wi=%b exp 0/1", mem_req, wait_instr); end
      step();
      n_checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0030) begin n_fail++; $display("FAIL b2b_reissue got req=%b addr=%h exp 1/0030", mem_req, mem_addr); end
      mem_ack = 1; mem_rdata = 32'h0000BBBB;
      step();
      mem_ack = 0; instr_req = 0;
      n_checks++; if (wait_instr !== 1'b0 || instr_rdata !== 32'h0000BBBB) begin n_fail++; $display("FAIL b2b_done2 got wi=%b rdata=%h exp 0/0000bbbb", wait_instr, instr_rdata); end
      step();
   endtask

   task automatic test_reset_during_acc();
      data_req = 1; data_we = 0; data_addr = 16'h5000;
      step();
      step();
      n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rst_acc_pre got req=%b exp 1", mem_req); end
      rst = 1;
      step();
      rst = 0; data_req = 0;
      n_checks++; if (mem_req !== 1'b0 || wait_data !== 1'b1 || data_segv !== 1'b0) begin n_fail++; $display("FAIL rst_acc got req=%b wd=%b segv=%b exp 0/1/0", mem_req, wait_data, data_segv); end
      mem_ack = 1; mem_rdata = 32'h00000BAD;
      step();
      mem_ack = 0;
      n_checks++; if (wait_data !== 1'b1 || data_segv !== 1'b0 || data_rdata !== 32'h0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_late_ack got wd=%b segv=%b rdata=%h req=%b exp 1/0/0/0", wait_data, data_segv, data_rdata, mem_req); end
      step();
      n_checks++; if (wait_data !== 1'b1 || data_segv !== 1'b0) begin n_fail++; $display("FAIL rst_after got wd=%b segv=%b exp 1/0", wait_data, data_segv); end
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_load_upper_edge();
      test_segv();
      test_priority();
      test_timeout();
      test_back_to_back();
      test_reset_during_acc();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
